// File: rtl/led_scan_receiver.sv
// LED array scan receiver.
// Brings the row-advance toggle and head-of-frame flag into the local drive
// clock, tracks the current row, captures each row's column pattern once the
// bus has settled, and drives one-hot row select plus PWM-gated column
// outputs. Sequence and missing-toggle errors are reported as sticky flags.
module led_scan_receiver #(
  parameter int          COLS        = 28,
  parameter int          ROWS        = 32,
  parameter int          SYNC_STAGES = 2,
  parameter int          CAPTURE_DLY = 12,
  parameter logic [23:0] TIMEOUT     = 24'd65535
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_ena,
  input  logic [COLS-1:0]          i_CULUMN_PATTERN,
  input  logic                     i_TOGGLE_SYNC,
  input  logic                     i_HEAD_FLAG,
  input  logic [7:0]               i_brightness,
  output logic [ROWS-1:0]          o_row_sel,
  output logic [COLS-1:0]          o_col_drv,
  output logic                     o_blank,
  output logic [$clog2(ROWS)-1:0]  o_row_idx,
  output logic                     o_frame_start,
  output logic                     o_err_seq,
  output logic                     o_err_timeout
);

  localparam int                 RW       = $clog2(ROWS);
  localparam int                 DLY_W    = $clog2(CAPTURE_DLY + 1);
  localparam logic [RW-1:0]      ROW_LAST = RW'(ROWS - 1);
  localparam logic [DLY_W-1:0]   DLY_MAX  = DLY_W'(CAPTURE_DLY);
  localparam logic [23:0]        TO_LAST  = TIMEOUT - 24'd1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BLANK   = 2'd1,
    ST_SETTLE  = 2'd2,
    ST_DISPLAY = 2'd3
  } state_t;

  // Synchroniser chains and edge detector
  logic [SYNC_STAGES-1:0] tog_sync_reg;
  logic [SYNC_STAGES-1:0] head_sync_reg;
  logic                   tog_prev_reg;
  logic                   sync_tog;
  logic                   sync_head;
  logic                   tog_evt;

  // Control state
  state_t                 state_reg, state_next;
  logic [RW-1:0]          row_reg, row_next;
  logic                   first_reg, first_next;
  logic [DLY_W-1:0]       dly_reg, dly_next;
  logic [23:0]            to_reg, to_next;
  logic                   err_seq_reg, err_seq_next;
  logic                   err_to_reg, err_to_next;
  logic                   fs_next;

  // Pattern sampling and captured row data
  logic [COLS-1:0]        pat_q_reg;
  logic [COLS-1:0]        pat_prev_reg;
  logic [COLS-1:0]        col_reg, col_next;
  logic                   capture_ok;

  // PWM and output staging
  logic [7:0]             pwm_reg, pwm_next;
  logic [ROWS-1:0]        row_dec;
  logic [ROWS-1:0]        row_sel_next;
  logic [COLS-1:0]        col_drv_next;
  logic                   blank_next;

  assign sync_tog  = tog_sync_reg[SYNC_STAGES-1];
  assign sync_head = head_sync_reg[SYNC_STAGES-1];
  assign tog_evt   = sync_tog ^ tog_prev_reg;

  // Synchronise toggle/head into i_clk; these keep running even when disabled
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tog_sync_reg  <= '0;
      head_sync_reg <= '0;
      tog_prev_reg  <= 1'b0;
    end else begin
      tog_sync_reg  <= {tog_sync_reg[SYNC_STAGES-2:0], i_TOGGLE_SYNC};
      head_sync_reg <= {head_sync_reg[SYNC_STAGES-2:0], i_HEAD_FLAG};
      tog_prev_reg  <= sync_tog;
    end
  end

  // The bus is accepted only when the live value and the last two samples agree
  assign capture_ok = (dly_reg >= DLY_MAX) &&
                      (i_CULUMN_PATTERN == pat_q_reg) &&
                      (pat_q_reg == pat_prev_reg);

  // Next-state logic: disable, row event, timeout, then per-state progress
  always_comb begin
    state_next   = state_reg;
    row_next     = row_reg;
    first_next   = first_reg;
    dly_next     = dly_reg;
    to_next      = to_reg;
    err_seq_next = err_seq_reg;
    err_to_next  = err_to_reg;
    col_next     = col_reg;
    fs_next      = 1'b0;

    if (!i_ena) begin
      // Disabled: park in IDLE at the last row so the next head maps to row 0
      state_next   = ST_IDLE;
      row_next     = ROW_LAST;
      first_next   = 1'b1;
      to_next      = '0;
      err_seq_next = 1'b0;
      err_to_next  = 1'b0;
    end else if (tog_evt) begin
      // Every toggle event restarts the row, even mid-settle or mid-display
      state_next = ST_BLANK;
      first_next = 1'b0;
      dly_next   = '0;
      to_next    = '0;
      if (sync_head) begin
        row_next = '0;
        fs_next  = 1'b1;
        if ((row_reg != ROW_LAST) && !first_reg) begin
          err_seq_next = 1'b1;
        end
      end else begin
        if (row_reg == ROW_LAST) begin
          row_next     = '0;
          err_seq_next = 1'b1;
        end else begin
          row_next = row_reg + RW'(1);
        end
      end
    end else if (state_reg == ST_IDLE) begin
      to_next = '0;
    end else if (to_reg == TO_LAST) begin
      // Too long without a row event: give up on the frame
      state_next  = ST_IDLE;
      row_next    = ROW_LAST;
      first_next  = 1'b1;
      to_next     = '0;
      err_to_next = 1'b1;
    end else begin
      to_next = to_reg + 24'd1;
      case (state_reg)
        ST_BLANK: begin
          state_next = ST_SETTLE;
          dly_next   = '0;
        end
        ST_SETTLE: begin
          if (capture_ok) begin
            col_next   = pat_q_reg;
            state_next = ST_DISPLAY;
          end else if (dly_reg < DLY_MAX) begin
            dly_next = dly_reg + DLY_W'(1);
          end
        end
        ST_DISPLAY: ;
        default: ;
      endcase
    end
  end

  // One-hot decode of the row that will be shown next cycle
  generate
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row_dec
      assign row_dec[gi] = (row_next == RW'(gi));
    end
  endgenerate

  // Output staging: PWM restarts at zero on every DISPLAY entry
  always_comb begin
    pwm_next     = '0;
    row_sel_next = '0;
    col_drv_next = '0;
    blank_next   = 1'b1;
    if (state_next == ST_DISPLAY) begin
      if (state_reg == ST_DISPLAY) begin
        pwm_next = pwm_reg + 8'd1;
      end
      blank_next   = 1'b0;
      row_sel_next = row_dec;
      if (pwm_next < i_brightness) begin
        col_drv_next = col_next;
      end
    end
  end

  // Control and data registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg    <= ST_IDLE;
      row_reg      <= ROW_LAST;
      first_reg    <= 1'b1;
      dly_reg      <= '0;
      to_reg       <= '0;
      err_seq_reg  <= 1'b0;
      err_to_reg   <= 1'b0;
      col_reg      <= '0;
      pwm_reg      <= '0;
      pat_q_reg    <= '0;
      pat_prev_reg <= '0;
    end else begin
      state_reg    <= state_next;
      row_reg      <= row_next;
      first_reg    <= first_next;
      dly_reg      <= dly_next;
      to_reg       <= to_next;
      err_seq_reg  <= err_seq_next;
      err_to_reg   <= err_to_next;
      col_reg      <= col_next;
      pwm_reg      <= pwm_next;
      pat_q_reg    <= i_CULUMN_PATTERN;
      pat_prev_reg <= pat_q_reg;
    end
  end

  // Registered drive outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_row_sel     <= '0;
      o_col_drv     <= '0;
      o_blank       <= 1'b1;
      o_frame_start <= 1'b0;
    end else begin
      o_row_sel     <= row_sel_next;
      o_col_drv     <= col_drv_next;
      o_blank       <= blank_next;
      o_frame_start <= fs_next;
    end
  end

  assign o_row_idx     = row_reg;
  assign o_err_seq     = err_seq_reg;
  assign o_err_timeout = err_to_reg;

endmodule

// File: tb/tb_led_scan_receiver.sv
// Directed bench for led_scan_receiver with an expectation queue.
module tb_led_scan_receiver;

  localparam logic [23:0] TMO = 24'd600;
  localparam int          TMO_I = 600;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic [27:0] pat;
  logic        tog;
  logic        head;
  logic [7:0]  bright;
  logic [31:0] row_sel;
  logic [27:0] col_drv;
  logic        blank;
  logic [4:0]  row_idx;
  logic        frame_start;
  logic        err_seq;
  logic        err_to;

  int total = 0;
  int bad   = 0;
  int fs_cnt = 0;

  typedef struct packed {
    logic [4:0]  row;
    logic        fs;
    logic        blank;
    logic [31:0] rsel;
    logic [27:0] col;
    logic        es;
    logic        et;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];

  led_scan_receiver #(
    .COLS(28), .ROWS(32), .SYNC_STAGES(2), .CAPTURE_DLY(12), .TIMEOUT(TMO)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_ena(ena),
    .i_CULUMN_PATTERN(pat),
    .i_TOGGLE_SYNC(tog),
    .i_HEAD_FLAG(head),
    .i_brightness(bright),
    .o_row_sel(row_sel),
    .o_col_drv(col_drv),
    .o_blank(blank),
    .o_row_idx(row_idx),
    .o_frame_start(frame_start),
    .o_err_seq(err_seq),
    .o_err_timeout(err_to)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count frame-start pulses away from the active edge
  always @(negedge clk) begin
    if (rst_n && frame_start) fs_cnt <= fs_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_push(input string tag, input logic [4:0] row, input logic fs,
                          input logic bl, input logic [31:0] rsel, input logic [27:0] col,
                          input logic es, input logic et);
    exp_t e;
    e.row = row; e.fs = fs; e.blank = bl; e.rsel = rsel; e.col = col; e.es = es; e.et = et;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check_out();
    exp_t  e;
    string t;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_empty: observed=0 expected=1");
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    $display("txn %s row=%0d fs=%0b blank=%0b sel=%h col=%h es=%0b et=%0b",
             t, row_idx, frame_start, blank, row_sel, col_drv, err_seq, err_to);
    chk({t, ".row_idx"},     64'(row_idx),     64'(e.row));
    chk({t, ".frame_start"}, 64'(frame_start), 64'(e.fs));
    chk({t, ".blank"},       64'(blank),       64'(e.blank));
    chk({t, ".row_sel"},     64'(row_sel),     64'(e.rsel));
    chk({t, ".col_drv"},     64'(col_drv),     64'(e.col));
    chk({t, ".err_seq"},     64'(err_seq),     64'(e.es));
    chk({t, ".err_timeout"}, 64'(err_to),      64'(e.et));
  endtask

  initial begin
    logic [27:0] p1, p4, w, col_e;
    int          on_cnt, k, pw;
    p1 = 28'h800_0000;
    p4 = 28'h5A5_A5A5;
    w  = 28'h0F0_F0F1;

    rst_n = 1'b0; ena = 1'b0; tog = 1'b0; head = 1'b0; pat = '0; bright = 8'd0;
    tick(3);
    exp_push("reset", 5'd31, 1'b0, 1'b1, 32'h0, 28'h0, 1'b0, 1'b0);
    check_out();
    rst_n = 1'b1; ena = 1'b1;
    tick(2);

    // First row of a frame, full brightness
    pat = p1; bright = 8'd255; head = 1'b1; tog = ~tog;
    exp_push("t1_pre", 5'd31, 1'b0, 1'b1, 32'h0, 28'h0, 1'b0, 1'b0);
    tick(2); check_out();
    exp_push("t1_frame", 5'd0, 1'b1, 1'b1, 32'h0, 28'h0, 1'b0, 1'b0);
    tick(1); check_out();
    head = 1'b0;
    exp_push("t1_settle", 5'd0, 1'b0, 1'b1, 32'h0, 28'h0, 1'b0, 1'b0);
    tick(1); check_out();
    exp_push("t1_settle_end", 5'd0, 1'b0, 1'b1, 32'h0, 28'h0, 1'b0, 1'b0);
    tick(12); check_out();
    exp_push("t1_display", 5'd0, 1'b0, 1'b0, 32'h1, p1, 1'b0, 1'b0);
    tick(1); check_out();
    on_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      if (col_drv === p1) on_cnt++;
      tick(1);
    end
    chk("t1_duty_255", 64'(on_cnt), 64'd255);

    // Walk the rest of the frame and wrap with a second head
    for (int r = 1; r < 32; r++) begin
      tog = ~tog;
      exp_push("t2_row", 5'(r), 1'b0, 1'b1, 32'h0, 28'h0, 1'b0, 1'b0);
      tick(3); check_out();
      tick(2);
    end
    head = 1'b1; tog = ~tog;
    exp_push("t2_wrap", 5'd0, 1'b1, 1'b1, 32'h0, 28'h0, 1'b0, 1'b0);
    tick(3); check_out();
    head = 1'b0;
    tick(2);
    chk("t2_frame_pulses", 64'(fs_cnt), 64'd2);

    // Head in the middle of a frame
    for (int r = 1; r <= 5; r++) begin
      tog = ~tog;
      exp_push("t3_row", 5'(r), 1'b0, 1'b1, 32'h0, 28'h0, 1'b0, 1'b0);
      tick(3); check_out();
      tick(2);
    end
    head = 1'b1; tog = ~tog;
    exp_push("t3_bad_head", 5'd0, 1'b1, 1'b1, 32'h0, 28'h0, 1'b1, 1'b0);
    tick(3); check_out();
    head = 1'b0;
    tick(2);
    tog = ~tog;
    exp_push("t3_sticky", 5'd1, 1'b0, 1'b1, 32'h0, 28'h0, 1'b1, 1'b0);
    tick(3); check_out();
    tick(2);
    ena = 1'b0;
    exp_push("t3_ena_off", 5'd31, 1'b0, 1'b1, 32'h0, 28'h0, 1'b0, 1'b0);
    tick(1); check_out();
    ena = 1'b1;
    exp_push("t3_cleared", 5'd31, 1'b0, 1'b1, 32'h0, 28'h0, 1'b0, 1'b0);
    tick(2); check_out();

    // Pattern bus wobbling every 2 cycles, final value driven at step 20
    for (int c = 0; c <= 22; c++) begin
      if (c == 0) begin head = 1'b1; tog = ~tog; end
      if (c == 3) head = 1'b0;
      if ((c % 2 == 0) && (c <= 20)) pat = (c == 20) ? p4 : 28'(32'h0ABC000 + c);
      k = c + 1;
      exp_push("t4_step", (k >= 3) ? 5'd0 : 5'd31, (k == 3), (k < 23),
               (k >= 23) ? 32'h1 : 32'h0, (k >= 23) ? p4 : 28'h0, 1'b0, 1'b0);
      tick(1); check_out();
    end

    // Toggle arriving mid-settle aborts the capture
    for (int c = 0; c <= 24; c++) begin
      if (c == 0) begin tog = ~tog; pat = w; end
      if (c == 8) tog = ~tog;
      k = c + 1;
      if (k < 3) begin
        exp_push("t5_old_row", 5'd0, 1'b0, 1'b0, 32'h1, p4, 1'b0, 1'b0);
      end else if (k < 11) begin
        exp_push("t5_row1", 5'd1, 1'b0, 1'b1, 32'h0, 28'h0, 1'b0, 1'b0);
      end else if (k < 25) begin
        exp_push("t5_row2", 5'd2, 1'b0, 1'b1, 32'h0, 28'h0, 1'b0, 1'b0);
      end else begin
        exp_push("t5_display", 5'd2, 1'b0, 1'b0, 32'h4, w, 1'b0, 1'b0);
      end
      tick(1); check_out();
    end

    // Toggle exactly at the timeout boundary, then a real timeout
    tog = ~tog;
    exp_push("t6_row3", 5'd3, 1'b0, 1'b1, 32'h0, 28'h0, 1'b0, 1'b0);
    tick(3); check_out();
    tick(TMO_I - 3);
    tog = ~tog;
    exp_push("t6_edge_toggle", 5'd4, 1'b0, 1'b1, 32'h0, 28'h0, 1'b0, 1'b0);
    tick(3); check_out();
    pw = (TMO_I + 2 - 17) % 256;
    col_e = (pw < 255) ? w : 28'h0;
    exp_push("t6_before_to", 5'd4, 1'b0, 1'b0, 32'h10, col_e, 1'b0, 1'b0);
    tick(TMO_I - 1); check_out();
    exp_push("t6_timeout", 5'd31, 1'b0, 1'b1, 32'h0, 28'h0, 1'b0, 1'b1);
    tick(1); check_out();
    exp_push("t6_idle_hold", 5'd31, 1'b0, 1'b1, 32'h0, 28'h0, 1'b0, 1'b1);
    tick(20); check_out();

    // Restart, dim to zero, then asynchronous reset mid-row
    head = 1'b1; tog = ~tog;
    exp_push("t7_display", 5'd0, 1'b0, 1'b0, 32'h1, w, 1'b0, 1'b1);
    tick(17); check_out();
    head = 1'b0; bright = 8'd0;
    exp_push("t7_dark", 5'd0, 1'b0, 1'b0, 32'h1, 28'h0, 1'b0, 1'b1);
    tick(1); check_out();
    rst_n = 1'b0;
    #1;
    exp_push("t7_async_reset", 5'd31, 1'b0, 1'b1, 32'h0, 28'h0, 1'b0, 1'b0);
    check_out();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
